// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, types and FSM encoding for the Layer 2 argmax stage
package nn_pkg;

    localparam int NUM_CLASSES   = 10;
    localparam int LOGIT_W       = 6;
    localparam int CLASS_IDX_W   = 4;
    localparam int MARGIN_THRESH = 2;

    typedef logic signed [LOGIT_W-1:0] logit_t;
    typedef logic [CLASS_IDX_W-1:0]    class_idx_t;

    // Most negative representable logit; seeds top2 so any real logit can displace it.
    localparam logit_t LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/layer2_argmax_if.sv
// rtl/layer2_argmax_if.sv - start/read-port/result bundle between Layer 2, argmax and display
// master: drives start and read_data (Layer 2 side), observes results.
// slave : the argmax stage; drives read_addr, busy, done and the result fields.
interface layer2_argmax_if;
    import nn_pkg::*;

    logic       start;
    class_idx_t read_addr;
    logit_t     read_data;
    logic       busy;
    logic       done;
    class_idx_t class_out;
    logit_t     top_logit;
    logic [LOGIT_W-1:0] margin;
    logic       low_conf;

    modport master (
        output start, read_data,
        input  read_addr, busy, done, class_out, top_logit, margin, low_conf
    );

    modport slave (
        input  start, read_data,
        output read_addr, busy, done, class_out, top_logit, margin, low_conf
    );

endinterface

// File: rtl/layer2_argmax_top2_tracker.sv
// rtl/layer2_argmax_top2_tracker.sv - running top-1/top-2 logit tracker with winning index
// Ports: clk, rst_n (async active-low); valid/first/idx/d: one logit per cycle when valid,
// first restarts tracking; top1/top2/cls: registered running maximum, runner-up, and index of top1.
module layer2_argmax_top2_tracker
    import nn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic       first,
    input  class_idx_t idx,
    input  logit_t     d,
    output logit_t     top1,
    output logit_t     top2,
    output class_idx_t cls
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top1 <= '0;
            top2 <= '0;
            cls  <= '0;
        end else if (valid) begin
            if (first) begin
                top1 <= d;
                top2 <= LOGIT_MIN;
                cls  <= '0;
            end else if (d > top1) begin
                // Strictly greater only: an equal later logit must not steal the win.
                top2 <= top1;
                top1 <= d;
                cls  <= idx;
            end else if (d > top2) begin
                top2 <= d;
            end
        end
    end

endmodule

// File: rtl/layer2_argmax.sv
// rtl/layer2_argmax.sv - scans Layer 2 logits and reports class, top logit, margin, low-confidence
// Ports: clk, rst_n (async active-low); bus (slave): start level in, read_addr out / read_data in
// (combinational read), busy, done, class_out, top_logit, margin, low_conf out.
module layer2_argmax
    import nn_pkg::*;
#(
    parameter int MARGIN_THRESH_P = MARGIN_THRESH
) (
    input  logic           clk,
    input  logic           rst_n,
    layer2_argmax_if.slave bus
);

    localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

    state_t     state_q, state_d;
    class_idx_t idx_q;
    logit_t     top1, top2;
    class_idx_t cls;
    logic [LOGIT_W:0]   diff;
    logic [LOGIT_W-1:0] margin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start is only looked at in IDLE (launch) and HOLD (release), so a level
    // held high yields exactly one scan.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_SCAN;
            ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_HOLD;
            ST_HOLD:   if (!bus.start) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (state_q == ST_IDLE) begin
            idx_q <= '0;
        end else if (state_q == ST_SCAN && idx_q != LAST_IDX) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign bus.read_addr = (state_q == ST_SCAN) ? idx_q : '0;
    assign bus.busy      = (state_q == ST_SCAN) || (state_q == ST_FINISH);
    assign bus.done      = (state_q == ST_HOLD);

    layer2_argmax_top2_tracker u_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (state_q == ST_SCAN),
        .first (idx_q == '0),
        .idx   (idx_q),
        .d     (bus.read_data),
        .top1  (top1),
        .top2  (top2),
        .cls   (cls)
    );

    // One extra bit keeps top1 - top2 exact; the result is never negative and
    // never exceeds 2^LOGIT_W - 1, so the low bits are the unsigned margin.
    assign diff        = {top1[LOGIT_W-1], top1} - {top2[LOGIT_W-1], top2};
    assign margin_next = diff[LOGIT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.class_out <= '0;
            bus.top_logit <= '0;
            bus.margin    <= '0;
            bus.low_conf  <= 1'b0;
        end else if (state_q == ST_FINISH) begin
            bus.class_out <= cls;
            bus.top_logit <= top1;
            bus.margin    <= margin_next;
            bus.low_conf  <= (int'(margin_next) < MARGIN_THRESH_P);
        end
    end

endmodule

// File: tb/tb_layer2_argmax.sv
// tb/tb_layer2_argmax.sv - self-checking bench for layer2_argmax
module tb_layer2_argmax;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer2_argmax_if bus ();

    layer2_argmax dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logit_t mem [NUM_CLASSES];
    assign bus.read_data = (int'(bus.read_addr) < NUM_CLASSES) ? mem[bus.read_addr] : '0;

    int checks = 0;
    int errors = 0;

    // Expected observable state, advanced by the stimulus along the documented timeline.
    int exp_busy, exp_done, exp_addr, exp_addr_valid;
    int exp_cls, exp_top, exp_margin, exp_low;
    int cmp_en = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en != 0) begin
            check("busy", int'(bus.busy), exp_busy);
            check("done", int'(bus.done), exp_done);
            if (exp_addr_valid != 0) check("read_addr", int'(bus.read_addr), exp_addr);
            check("class_out", int'(bus.class_out), exp_cls);
            check("top_logit", int'(bus.top_logit), exp_top);
            check("margin", int'(bus.margin), exp_margin);
            check("low_conf", int'(bus.low_conf), exp_low);
        end
    end

    // Reference: first index of the maximum wins; runner-up is the largest of the rest.
    task automatic ref_argmax(output int cls, output int top, output int mar);
        int second;
        cls = 0;
        top = int'(mem[0]);
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (int'(mem[i]) > top) begin
                top = int'(mem[i]);
                cls = i;
            end
        end
        second = -1000;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (i != cls && int'(mem[i]) > second) second = int'(mem[i]);
        end
        mar = top - second;
    endtask

    task automatic load(input int v[NUM_CLASSES]);
        for (int i = 0; i < NUM_CLASSES; i++) mem[i] = logit_t'(v[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_busy = 0; exp_done = 0; exp_addr = 0; exp_addr_valid = 1;
        exp_cls = 0; exp_top = 0; exp_margin = 0; exp_low = 0;
    endtask

    // Called in IDLE just after a clock edge; start stays high for 12 + extra_hold edges.
    task automatic run_scan(input int extra_hold);
        int c, t, m;
        ref_argmax(c, t, m);
        bus.start = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            tick();
            if (e <= 9) begin
                exp_busy = 1; exp_addr = e; exp_addr_valid = 1;
            end else if (e == 10) begin
                exp_addr_valid = 0;
            end else begin
                exp_busy = 0; exp_done = 1;
                exp_cls = c; exp_top = t; exp_margin = m; exp_low = (m < MARGIN_THRESH) ? 1 : 0;
            end
        end
        repeat (extra_hold) tick();
        bus.start = 1'b0;
        tick();
        exp_done = 0; exp_addr = 0; exp_addr_valid = 1;
    endtask

    task automatic pin_results(input string tag, input int c, input int t, input int m, input int l);
        check({tag, "_class"}, int'(bus.class_out), c);
        check({tag, "_top"}, int'(bus.top_logit), t);
        check({tag, "_margin"}, int'(bus.margin), m);
        check({tag, "_lowconf"}, int'(bus.low_conf), l);
    endtask

    initial begin
        int vec[NUM_CLASSES];
        int c, t, m;
        bus.start = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) mem[i] = '0;
        clear_exp();
        rst_n = 1'b0;
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic vector; model pinned against hand-computed values first.
        vec = '{0, 3, -5, 12, 1, 0, -1, 2, 4, -32};
        load(vec);
        ref_argmax(c, t, m);
        check("model_basic_cls", c, 3);
        check("model_basic_margin", m, 8);
        run_scan(0);
        pin_results("basic", 3, 12, 8, 0);

        // Tie: lowest index wins, margin 0.
        vec = '{5, -3, 20, 0, 4, 1, -7, 20, 2, 5};
        load(vec);
        ref_argmax(c, t, m);
        check("model_tie_cls", c, 2);
        check("model_tie_margin", m, 0);
        run_scan(1);
        pin_results("tie", 2, 20, 0, 1);

        // Extremes.
        vec = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, 31};
        load(vec);
        run_scan(0);
        pin_results("max_margin", 9, 31, 63, 0);
        vec = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32};
        load(vec);
        run_scan(0);
        pin_results("all_min", 0, -32, 0, 1);

        // start held 30 cycles: one scan only, then immediate relaunch with new logits.
        vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        load(vec);
        run_scan(18);
        pin_results("held", 9, 10, 1, 1);
        vec = '{-4, 10, -2, 3, 0, 6, -9, 1, 2, -1};
        load(vec);
        run_scan(0);
        pin_results("relaunch", 1, 10, 4, 0);

        // Reset five cycles into a scan: everything clears at once.
        vec = '{7, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        load(vec);
        bus.start = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            exp_busy = 1; exp_addr = e; exp_addr_valid = 1;
        end
        rst_n = 1'b0;
        #1;
        clear_exp();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_addr", int'(bus.read_addr), 0);
        pin_results("rst", 0, 0, 0, 0);
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(0);
        pin_results("post_rst", 0, 7, 6, 0);

        // Randomized scans; narrow value ranges on odd iterations to provoke ties.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (it % 2 == 1) vec[i] = int'($urandom_range(0, 6)) - 3;
                else             vec[i] = int'($urandom_range(0, 63)) - 32;
            end
            load(vec);
            run_scan(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
